// File: rtl/uart_receiver.sv
// 8N1 UART receiver: two-flop synchroniser, mid-bit start validation, LSB-first
// centre sampling and stop-bit check with one-cycle valid / framing-error strobes.
module uart_receiver #(
  parameter int CLKS_PER_BIT = 10416
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic [7:0] data,
  output logic       data_valid,
  output logic       frame_err,
  output logic       busy,
  output logic [2:0] state_dbg_o
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_MID  = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } state_e;

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    bit_idx_q;
  logic [7:0]    sh_q;
  logic [7:0]    data_q;
  logic          data_valid_q;
  logic          frame_err_q;
  logic          rxd_meta_q;
  logic          rxd_s_q;

  // Synchroniser resets to the idle (high) line level so reset never looks like a start bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rxd_meta_q <= 1'b1;
      rxd_s_q    <= 1'b1;
    end else begin
      rxd_meta_q <= rxd;
      rxd_s_q    <= rxd_meta_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      bit_idx_q    <= '0;
      sh_q         <= '0;
      data_q       <= '0;
      data_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      data_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (!rxd_s_q) begin
            cnt_q   <= '0;
            state_q <= S_START;
          end
        end
        S_START: begin
          if (cnt_q == CNT_MID) begin
            if (!rxd_s_q) begin
              cnt_q     <= '0;
              bit_idx_q <= '0;
              state_q   <= S_DATA;
            end else begin
              state_q   <= S_IDLE;
            end
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        S_DATA: begin
          if (cnt_q == CNT_LAST) begin
            sh_q  <= {rxd_s_q, sh_q[7:1]};
            cnt_q <= '0;
            if (bit_idx_q == 3'd7) begin
              state_q <= S_STOP;
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
            end
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        S_STOP: begin
          // Leaving at mid-stop-bit leaves half a bit to catch a back-to-back start.
          if (cnt_q == CNT_LAST) begin
            if (rxd_s_q) begin
              data_q       <= sh_q;
              data_valid_q <= 1'b1;
              state_q      <= S_IDLE;
            end else begin
              frame_err_q  <= 1'b1;
              state_q      <= S_BREAK;
            end
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        S_BREAK: begin
          if (rxd_s_q) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign data        = data_q;
  assign data_valid  = data_valid_q;
  assign frame_err   = frame_err_q;
  assign busy        = (state_q != S_IDLE);
  assign state_dbg_o = state_q;

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver at 16 clocks per bit: single byte, back-to-back,
// start glitch, framing error/break, mid-frame reset and a 0x5A frame.
module tb_uart_receiver;

  localparam int CPB = 16;

  logic       clk;
  logic       rst;
  logic       rxd;
  logic [7:0] data;
  logic       data_valid;
  logic       frame_err;
  logic       busy;
  logic [2:0] state_dbg;

  int checks = 0;
  int errors = 0;

  uart_receiver #(.CLKS_PER_BIT(CPB)) dut (
    .clk         (clk),
    .rst         (rst),
    .rxd         (rxd),
    .data        (data),
    .data_valid  (data_valid),
    .frame_err   (frame_err),
    .busy        (busy),
    .state_dbg_o (state_dbg)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Output monitor, sampled on the falling edge
  int         cyc       = 0;
  int         dv_cnt    = 0;
  int         fe_cnt    = 0;
  int         both_cnt  = 0;
  int         busy_cyc  = 0;
  int         last_dv_cyc = 0;
  int         prev_dv_cyc = 0;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (data_valid) begin
      dv_cnt      = dv_cnt + 1;
      prev_dv_cyc = last_dv_cyc;
      last_dv_cyc = cyc;
      got_q.push_back(data);
    end
    if (frame_err) fe_cnt = fe_cnt + 1;
    if (data_valid && frame_err) both_cnt = both_cnt + 1;
    if (busy) busy_cyc = busy_cyc + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      errors = errors + 1;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Driver tasks: inputs change 1 time unit after a rising edge
  task automatic idle(input int n);
    rxd = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    rxd = b;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(stop);
  endtask

  // Compare every byte the receiver produced against the expected queue
  task automatic drain_scoreboard(input string tag);
    logic [7:0] e;
    logic [7:0] g;
    check({tag, "_count"}, got_q.size(), exp_q.size());
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      check({tag, "_byte"}, g, e);
    end
    exp_q.delete();
    got_q.delete();
  endtask

  int t0;
  int dv0;
  int fe0;
  int busy0;
  int lat;
  int gap;

  initial begin
    rst = 1'b1;
    rxd = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_data", data, 8'h00);
    check("rst_valid", data_valid, 1'b0);
    check("rst_ferr", frame_err, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_state", state_dbg, 3'd0);
    rst = 1'b0;
    idle(5);

    // Single byte 0xA5: valid seen on the 155th falling edge after the line drops
    dv0 = dv_cnt; fe0 = fe_cnt; t0 = cyc;
    exp_q.push_back(8'hA5);
    send_byte(8'hA5, 1'b1);
    idle(10);
    lat = last_dv_cyc - t0;
    check("a5_latency_in_window", (lat >= 153 && lat <= 157), 1'b1);
    check("a5_data", data, 8'hA5);
    check("a5_valid_pulses", dv_cnt - dv0, 1);
    check("a5_ferr_pulses", fe_cnt - fe0, 0);
    drain_scoreboard("a5");

    // Back-to-back 0x00 then 0xFF with one stop bit and no gap
    dv0 = dv_cnt;
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    send_byte(8'h00, 1'b1);
    send_byte(8'hFF, 1'b1);
    idle(10);
    gap = last_dv_cyc - prev_dv_cyc;
    check("b2b_valid_pulses", dv_cnt - dv0, 2);
    check("b2b_gap_in_window", (gap >= 159 && gap <= 161), 1'b1);
    drain_scoreboard("b2b");

    // Start glitch: 4 low cycles must be rejected at mid-bit
    dv0 = dv_cnt; fe0 = fe_cnt; busy0 = busy_cyc;
    rxd = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    idle(30);
    check("glitch_busy_max8", ((busy_cyc - busy0) >= 1 && (busy_cyc - busy0) <= 8), 1'b1);
    check("glitch_busy_low", busy, 1'b0);
    check("glitch_no_valid", dv_cnt - dv0, 0);
    check("glitch_no_ferr", fe_cnt - fe0, 0);
    check("glitch_data_kept", data, 8'hFF);

    // Good 0x3C, then 0x81 with a low stop bit followed by a held-low break
    send_byte(8'h3C, 1'b1);
    idle(10);
    check("pre_break_data", data, 8'h3C);
    dv0 = dv_cnt; fe0 = fe_cnt;
    send_byte(8'h81, 1'b0);
    rxd = 1'b0;
    repeat (50) @(posedge clk);
    #1;
    check("break_busy_mid", busy, 1'b1);
    repeat (50) @(posedge clk);
    #1;
    check("break_busy_end", busy, 1'b1);
    check("break_ferr_once", fe_cnt - fe0, 1);
    check("break_no_valid", dv_cnt - dv0, 0);
    check("break_data_kept", data, 8'h3C);
    idle(5);
    check("break_busy_released", busy, 1'b0);
    send_byte(8'h55, 1'b1);
    idle(10);
    check("after_break_data", data, 8'h55);
    check("after_break_ferr", fe_cnt - fe0, 1);

    // Reset during data bit 4 of 0xF0
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b0);
    rxd = 1'b1;
    repeat (CPB / 2) @(posedge clk);
    #1;
    check("mid_busy_before_rst", busy, 1'b1);
    rst = 1'b1;
    #1;
    check("mid_rst_data", data, 8'h00);
    check("mid_rst_valid", data_valid, 1'b0);
    check("mid_rst_ferr", frame_err, 1'b0);
    check("mid_rst_busy", busy, 1'b0);
    idle(4);
    rst = 1'b0;
    idle(20);
    dv0 = dv_cnt;
    send_byte(8'h0F, 1'b1);
    idle(10);
    check("post_rst_data", data, 8'h0F);
    check("post_rst_valid", dv_cnt - dv0, 1);

    // 0x5A frame, as the transmitter loopback would produce
    dv0 = dv_cnt;
    exp_q.push_back(8'h5A);
    got_q.delete();
    send_byte(8'h5A, 1'b1);
    idle(10);
    check("lb_data", data, 8'h5A);
    drain_scoreboard("lb");

    check("never_valid_and_ferr", both_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
